// File: rtl/bram.sv
// Single-port 32-bit block RAM with per-byte write strobes and a registered, read-first output.
// Define BRAM_INIT_ZERO_EN to start every word at zero; otherwise contents are undefined until written.
module bram #(
    parameter int AddressBitWidth = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 write_enable,
    input  logic [AddressBitWidth-1:0] address,
    input  logic [31:0]                data_in,
    output logic [31:0]                data_out
);

    localparam int Depth = 1 << AddressBitWidth;

    logic [31:0] mem [Depth];

`ifdef BRAM_INIT_ZERO_EN
    // A tag store built on this block starts with every valid/dirty bit clear.
    initial begin
        for (int i = 0; i < Depth; i++) begin
            mem[i] = 32'h0;
        end
    end
`else
`endif

    // Read and write share one clocked block so the tools map it onto a
    // read-first BSRAM port; the output register sees the pre-write word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= 32'h0;
        end else begin
            data_out <= mem[address];
            for (int i = 0; i < 4; i++) begin
                if (write_enable[i]) begin
                    mem[address][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bram.sv
// Scoreboard bench for bram: the driver queues the expected read word, a monitor
// compares it against data_out one cycle later.
module tb_bram;

    logic        clk;
    logic        rst_n;
    logic [3:0]  write_enable;
    logic [9:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    logic chk;
    int   checks;
    int   passes;

    bram #(.AddressBitWidth(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_enable (write_enable),
        .address      (address),
        .data_in      (data_in),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs on the falling edge; optionally queue the word
    // data_out must show after the following rising edge.
    task automatic step(input logic rn, input logic [3:0] we, input logic [9:0] a,
                        input logic [31:0] d, input logic c, input logic [31:0] e,
                        input string nm);
        exp_t x;
        @(negedge clk);
        rst_n        = rn;
        write_enable = we;
        address      = a;
        data_in      = d;
        chk          = c;
        if (c) begin
            x.exp  = e;
            x.name = nm;
            sb.push_back(x);
        end
    endtask

    always @(posedge clk) begin
        logic sample;
        exp_t x;
        sample = chk;
        #1;
        if (sample) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL scoreboard_underflow: data_out=%h with no expected entry", data_out);
            end else begin
                x = sb.pop_front();
                if (data_out !== x.exp)
                    $display("FAIL %s: data_out=%h required=%h", x.name, data_out, x.exp);
                else
                    passes++;
            end
        end
    end

    initial begin
        checks = 0;
        passes = 0;
        chk = 1'b0;
        rst_n = 1'b0;
        write_enable = 4'h0;
        address = '0;
        data_in = 32'h0;

        // Reset holds data_out at zero and blocks the write.
        step(1'b0, 4'hF, 10'd0, 32'hDEADBEEF, 1'b1, 32'h0, "reset_0");
        step(1'b0, 4'hF, 10'd0, 32'hDEADBEEF, 1'b1, 32'h0, "reset_1");
`ifdef BRAM_INIT_ZERO_EN
        step(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 32'h0, "reset_write_suppressed");
`else
        step(1'b1, 4'h0, 10'd0, 32'h0, 1'b0, 32'h0, "");
`endif

        // Full word write and readback.
        step(1'b1, 4'hF, 10'd5, 32'h12345678, 1'b0, 32'h0, "");
        step(1'b1, 4'h0, 10'd5, 32'h0, 1'b1, 32'h12345678, "full_write");

        // Lanes 0 and 2 only; the write edge itself returns the old word.
        step(1'b1, 4'b0101, 10'd5, 32'hAABBCCDD, 1'b1, 32'h12345678, "lane_write_old");
        step(1'b1, 4'h0, 10'd5, 32'h0, 1'b1, 32'h12BB56DD, "byte_lanes");

        // Read-first collision.
        step(1'b1, 4'hF, 10'd7, 32'h11111111, 1'b0, 32'h0, "");
        step(1'b1, 4'hF, 10'd7, 32'h22222222, 1'b1, 32'h11111111, "collision_old");
        step(1'b1, 4'h0, 10'd7, 32'h0, 1'b1, 32'h22222222, "collision_new");

        // Back-to-back stream; addresses 5 and 7 return their previous words.
        for (int k = 0; k < 8; k++) begin
            if (k == 5)
                step(1'b1, 4'hF, 10'(k), 32'(k) * 32'h01010101, 1'b1, 32'h12BB56DD, "stream_wr_old5");
            else if (k == 7)
                step(1'b1, 4'hF, 10'(k), 32'(k) * 32'h01010101, 1'b1, 32'h22222222, "stream_wr_old7");
            else
                step(1'b1, 4'hF, 10'(k), 32'(k) * 32'h01010101, 1'b0, 32'h0, "");
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 4'h0, 10'(k), 32'h0, 1'b1, 32'(k) * 32'h01010101, $sformatf("stream_rd_%0d", k));
        end

        // Boundary addresses.
        step(1'b1, 4'hF, 10'd0,    32'hA5A5A5A5, 1'b0, 32'h0, "");
        step(1'b1, 4'hF, 10'd1023, 32'h5A5A5A5A, 1'b0, 32'h0, "");
        step(1'b1, 4'h0, 10'd0,    32'h0, 1'b1, 32'hA5A5A5A5, "addr_low");
        step(1'b1, 4'h0, 10'd1023, 32'h0, 1'b1, 32'h5A5A5A5A, "addr_high");
        step(1'b1, 4'h0, 10'd1,    32'h0, 1'b1, 32'h01010101, "addr_neighbour");

        // Mid-run reset clears the output but neither writes nor clears the array.
        step(1'b0, 4'hF, 10'd1023, 32'h0, 1'b1, 32'h0, "reset_midrun");
        step(1'b1, 4'h0, 10'd1023, 32'h0, 1'b1, 32'h5A5A5A5A, "reset_keeps_array");

        step(1'b1, 4'h0, 10'd0, 32'h0, 1'b0, 32'h0, "");
        repeat (3) @(negedge clk);

        checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: entries_left=%0d required=0", sb.size());
        else
            passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
